game_data_regs: RTL and testbench

//  Parametrised game-state register file on the Avalon-MM slave bus: bus R/W of state/scratch regs with byte enables.

---
 rtl/game_data_regs.sv | 152 +++++++++++++++
 tb/tb_game_data_regs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_data_regs.sv
// Game-state register file on an Avalon-MM slave port.
// Holds STATE, CTRL, PEND, per-player saturating score counters and scratch
// registers. Reads are registered with a one-cycle Read_valid. A level
// interrupt is raised from enabled pending events.
module game_data_regs #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned SCORE_MAX   = 9999
) (
    input  logic                          Clk,
    input  logic                          Reset_h,
    input  logic                          Chip_select_h,
    input  logic                          Read_h,
    input  logic                          Write_h,
    input  logic [ADDR_W-1:0]             Address,
    input  logic [DATA_W/8-1:0]           Byte_enable,
    input  logic [DATA_W-1:0]             Write_data,
    input  logic [NUM_PLAYERS-1:0]        Score_inc,
    output logic [DATA_W-1:0]             Read_data,
    output logic                          Read_valid,
    output logic [DATA_W-1:0]             Export_state,
    output logic [NUM_PLAYERS*DATA_W-1:0] Export_scores,
    output logic                          Irq
);

    localparam int unsigned SCORE_BASE = 3;
    localparam logic [DATA_W-1:0] SCORE_MAX_W = DATA_W'(SCORE_MAX);
    // Only the state bit and one bit per player exist in PEND.
    localparam logic [DATA_W-1:0] PEND_MASK = DATA_W'((1 << (NUM_PLAYERS + 1)) - 1);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                irq_q, irq_d;

    logic                wr_en;
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_mask;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   pend_set;
    logic [DATA_W-1:0]   pend_clr;
    logic                clr_scores;

    // Decode the addressed register, its current value and the byte-merged write value.
    always_comb begin
        wr_en   = Chip_select_h & Write_h;
        wr_hit  = '0;
        cur_val = '0;
        wr_mask = '0;
        for (int a = 0; a < int'(NUM_REGS); a++) begin
            if (Address == ADDR_W'(a)) begin
                cur_val   = regs_q[a];
                wr_hit[a] = wr_en;
            end
        end
        for (int b = 0; b < int'(DATA_W / 8); b++) begin
            wr_mask[8*b +: 8] = {8{Byte_enable[b]}};
        end
        merged = (cur_val & ~wr_mask) | (Write_data & wr_mask);
    end

    // Next-state for every register, including hardware score updates and PEND set/clear.
    always_comb begin
        for (int a = 0; a < int'(NUM_REGS); a++) begin
            regs_d[a] = regs_q[a];
        end
        pend_set   = '0;
        pend_clr   = '0;
        clr_scores = 1'b0;

        if (wr_hit[0]) begin
            regs_d[0] = merged;
            if (merged != regs_q[0]) begin
                pend_set[0] = 1'b1;
            end
        end

        // CLR_SCORES is a strobe only; just IRQ_EN is kept.
        if (wr_hit[1]) begin
            regs_d[1]  = {{(DATA_W-1){1'b0}}, merged[0]};
            clr_scores = wr_mask[1] & Write_data[1];
        end

        if (wr_hit[2]) begin
            pend_clr = Write_data & wr_mask;
        end

        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (clr_scores) begin
                regs_d[SCORE_BASE+i] = '0;
            end else if (wr_hit[SCORE_BASE+i]) begin
                regs_d[SCORE_BASE+i] = (merged > SCORE_MAX_W) ? SCORE_MAX_W : merged;
            end else if (Score_inc[i]) begin
                regs_d[SCORE_BASE+i] = (regs_q[SCORE_BASE+i] >= SCORE_MAX_W) ?
                                       SCORE_MAX_W : regs_q[SCORE_BASE+i] + DATA_W'(1);
                pend_set[1+i] = 1'b1;
            end
        end

        for (int a = int'(SCORE_BASE + NUM_PLAYERS); a < int'(NUM_REGS); a++) begin
            if (wr_hit[a]) begin
                regs_d[a] = merged;
            end
        end

        // Hardware set wins over a same-cycle W1C.
        regs_d[2] = ((regs_q[2] & ~pend_clr) | pend_set) & PEND_MASK;
    end

    // Registered read path and interrupt next-state.
    always_comb begin
        rd_valid_d = Chip_select_h & Read_h;
        rd_data_d  = rd_valid_d ? cur_val : '0;
        irq_d      = regs_q[1][0] & (|regs_q[2]);
    end

    // State update; synchronous reset overrides all bus and score activity.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            for (int a = 0; a < int'(NUM_REGS); a++) begin
                regs_q[a] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int a = 0; a < int'(NUM_REGS); a++) begin
                regs_q[a] <= regs_d[a];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    // Exports are taken straight from the register contents.
    always_comb begin
        Export_scores = '0;
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            Export_scores[i*DATA_W +: DATA_W] = regs_q[SCORE_BASE+i];
        end
        Export_state = regs_q[0];
        Read_data    = rd_data_q;
        Read_valid   = rd_valid_q;
        Irq          = irq_q;
    end

endmodule

// File: tb/tb_game_data_regs.sv
// Directed bench for game_data_regs (NUM_REGS=12 so address 15 is out of range).
module tb_game_data_regs;

    logic        Clk = 1'b0;
    logic        Reset_h;
    logic        Chip_select_h;
    logic        Read_h;
    logic        Write_h;
    logic [3:0]  Address;
    logic [3:0]  Byte_enable;
    logic [31:0] Write_data;
    logic [1:0]  Score_inc;
    logic [31:0] Read_data;
    logic        Read_valid;
    logic [31:0] Export_state;
    logic [63:0] Export_scores;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        rv;

    game_data_regs #(
        .DATA_W     (32),
        .NUM_REGS   (12),
        .ADDR_W     (4),
        .NUM_PLAYERS(2),
        .SCORE_MAX  (9999)
    ) dut (
        .Clk          (Clk),
        .Reset_h      (Reset_h),
        .Chip_select_h(Chip_select_h),
        .Read_h       (Read_h),
        .Write_h      (Write_h),
        .Address      (Address),
        .Byte_enable  (Byte_enable),
        .Write_data   (Write_data),
        .Score_inc    (Score_inc),
        .Read_data    (Read_data),
        .Read_valid   (Read_valid),
        .Export_state (Export_state),
        .Export_scores(Export_scores),
        .Irq          (Irq)
    );

    always #5 Clk = ~Clk;

    // All tasks start and end on a falling edge.
    task automatic bus_write(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
        Chip_select_h = 1'b1; Write_h = 1'b1; Address = addr; Byte_enable = be; Write_data = data;
        @(negedge Clk);
        Chip_select_h = 1'b0; Write_h = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data, output logic valid);
        Chip_select_h = 1'b1; Read_h = 1'b1; Address = addr;
        @(negedge Clk);
        Chip_select_h = 1'b0; Read_h = 1'b0;
        data  = Read_data;
        valid = Read_valid;
    endtask

    task automatic pulse(input logic [1:0] inc);
        Score_inc = inc;
        @(negedge Clk);
        Score_inc = 2'b00;
    endtask

    task automatic test_reset();
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", Irq); end
        checks++; if (Read_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", Read_valid); end
        checks++; if (Export_scores !== 64'd0) begin errors++; $display("FAIL reset_scores got %h exp 0", Export_scores); end
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd, rv);
            checks++; if (rv !== 1'b1) begin errors++; $display("FAIL reset_rd_valid addr %0d got %b exp 1", a, rv); end
            checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd addr %0d got %h exp 0", a, rd); end
            @(negedge Clk);
            checks++; if (Read_valid !== 1'b0) begin errors++; $display("FAIL rv_one_cycle addr %0d got %b exp 0", a, Read_valid); end
        end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL reset_irq2 got %b exp 0", Irq); end
    endtask

    task automatic test_state_write();
        bus_write(4'd0, 4'b0001, 32'h0000_0003);
        bus_write(4'd0, 4'b0010, 32'h0000_0500);
        checks++; if (Export_state !== 32'h503) begin errors++; $display("FAIL state_export got %h exp 503", Export_state); end
        bus_read(4'd0, rd, rv);
        checks++; if (rd !== 32'h503) begin errors++; $display("FAIL state_rd got %h exp 503", rd); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL state_pend got %h exp 1", rd); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got %b exp 0", Irq); end
        bus_write(4'd1, 4'b0001, 32'h1);
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL irq_delay got %b exp 0", Irq); end
        @(negedge Clk);
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", Irq); end
        bus_read(4'd1, rd, rv);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_rd got %h exp 1", rd); end
        bus_write(4'd2, 4'b0001, 32'h1);
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL irq_clr_delay got %b exp 1", Irq); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pend_w1c got %h exp 0", rd); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", Irq); end
        // Same value rewritten: no state-changed event.
        bus_write(4'd0, 4'b1111, 32'h503);
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL state_same_val got %h exp 0", rd); end
    endtask

    task automatic test_scores();
        pulse(2'b10); pulse(2'b10); pulse(2'b10);
        checks++; if (Export_scores[63:32] !== 32'd3) begin errors++; $display("FAIL score1_export got %0d exp 3", Export_scores[63:32]); end
        bus_read(4'd4, rd, rv);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL score1_rd got %0d exp 3", rd); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL score1_pend got %h exp 4", rd); end
        bus_write(4'd3, 4'b1111, 32'd9998);
        pulse(2'b01); pulse(2'b01);
        checks++; if (Export_scores[31:0] !== 32'd9999) begin errors++; $display("FAIL score0_sat got %0d exp 9999", Export_scores[31:0]); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h6) begin errors++; $display("FAIL score0_pend got %h exp 6", rd); end
        bus_write(4'd4, 4'b1111, 32'd20000);
        bus_read(4'd4, rd, rv);
        checks++; if (rd !== 32'd9999) begin errors++; $display("FAIL score_wr_clamp got %0d exp 9999", rd); end
    endtask

    task automatic test_priority();
        bus_write(4'd2, 4'b1111, 32'hFFFF_FFFF);
        Score_inc = 2'b01;
        bus_write(4'd3, 4'b1111, 32'd7);
        Score_inc = 2'b00;
        checks++; if (Export_scores[31:0] !== 32'd7) begin errors++; $display("FAIL wr_beats_inc got %0d exp 7", Export_scores[31:0]); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL inc_dropped_pend got %h exp 0", rd); end
        Score_inc = 2'b11;
        bus_write(4'd1, 4'b0001, 32'h2);
        Score_inc = 2'b00;
        checks++; if (Export_scores !== 64'd0) begin errors++; $display("FAIL clr_scores got %h exp 0", Export_scores); end
        bus_read(4'd1, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_clr_rd got %h exp 0", rd); end
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_pend got %h exp 0", rd); end
    endtask

    task automatic test_pend_collision();
        Score_inc = 2'b01;
        bus_write(4'd2, 4'b1111, 32'h2);
        Score_inc = 2'b00;
        bus_read(4'd2, rd, rv);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL set_beats_clr got %h exp 2", rd); end
        checks++; if (Export_scores[31:0] !== 32'd1) begin errors++; $display("FAIL collide_score got %0d exp 1", Export_scores[31:0]); end
        bus_read(4'd15, rd, rv);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL oor_valid got %b exp 1", rv); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_data got %h exp 0", rd); end
        bus_write(4'd11, 4'b1100, 32'hDEAD_BEEF);
        bus_read(4'd11, rd, rv);
        checks++; if (rd !== 32'hDEAD_0000) begin errors++; $display("FAIL scratch_be got %h exp dead0000", rd); end
        bus_write(4'd13, 4'b1111, 32'h1234_5678);
        bus_read(4'd13, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_write got %h exp 0", rd); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", Irq); end
    endtask

    task automatic test_back_to_back();
        bus_write(4'd5, 4'b1111, 32'h1111_1111);
        Read_h = 1'b1;
        bus_read(4'd5, rd, rv);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rw_old got %h exp 11111111", rd); end
        bus_write(4'd5, 4'b1111, 32'h2222_2222);
        bus_read(4'd5, rd, rv);
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL rw_new got %h exp 22222222", rd); end
        bus_write(4'd1, 4'b0001, 32'h1);
        @(negedge Clk);
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL irq_reenable got %b exp 1", Irq); end
    endtask

    task automatic test_reset_mid_read();
        Reset_h = 1'b1; Chip_select_h = 1'b1; Read_h = 1'b1; Address = 4'd0;
        @(negedge Clk);
        Reset_h = 1'b0; Chip_select_h = 1'b0; Read_h = 1'b0;
        checks++; if (Read_valid !== 1'b0) begin errors++; $display("FAIL rst_read_valid got %b exp 0", Read_valid); end
        checks++; if (Read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data got %h exp 0", Read_data); end
        checks++; if (Export_state !== 32'h0) begin errors++; $display("FAIL rst_state got %h exp 0", Export_state); end
        checks++; if (Export_scores !== 64'h0) begin errors++; $display("FAIL rst_scores got %h exp 0", Export_scores); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", Irq); end
        bus_read(4'd11, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_scratch got %h exp 0", rd); end
    endtask

    initial begin
        Reset_h = 1'b1; Chip_select_h = 1'b0; Read_h = 1'b0; Write_h = 1'b0;
        Address = '0; Byte_enable = '0; Write_data = '0; Score_inc = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_h = 1'b0;
        test_reset();
        test_state_write();
        test_scores();
        test_priority();
        test_pend_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
